axi_wr_txn_monitor: RTL and testbench
=====================================

Name: axi_wr_txn_monitor

Overview:
- Passive, parametrised AXI4 write-path watchdog between a master and a slave port.
- Tracks up to MaxTxns outstanding writes across three phases: AW accepted, W data, and B response.
- Per-phase cycle budgets are enforced. A budget overrun, an unsolicited B, or a full tracker raises a latched IRQ/reset request with fault metadata for the register file.
- Successor to the single-budget write guard: adds separate W/B budgets, W-beat ordering, oldest-first B matching, a blocking/non-blocking full mode, and a fault record.

Parameters:
IdWidth, 4, AXI ID width
AddrWidth, 32, AXI address width
MaxTxns, 8, tracker slots (>=2)
CntWidth, 16, per-slot cycle counter and budget width
BlockWhenFull, 1, 1: gate aw_valid/aw_ready when full; 0: pass through and flag overflow fault

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  monitoring enable; 0 flushes all slots, no faults raised
aw_valid_i  in  1  master AW valid
aw_ready_i  in  1  slave AW ready
aw_id_i  in  IdWidth  AW ID
aw_addr_i  in  AddrWidth  AW address
aw_len_i  in  8  AW burst length (beats-1)
aw_valid_o  out  1  AW valid toward slave (gated)
aw_ready_o  out  1  AW ready toward master (gated)
w_valid_i  in  1  W valid
w_ready_i  in  1  W ready
w_last_i  in  1  W last
b_valid_i  in  1  B valid
b_ready_i  in  1  B ready
b_id_i  in  IdWidth  B ID
budget_w_i  in  CntWidth  allowed cycles per W beat
budget_b_i  in  CntWidth  allowed cycles from W last to B handshake
clear_i  in  1  clears latched fault and flushes slots
full_o  out  1  no free slot
outstanding_o  out  $clog2(MaxTxns+1)  busy slot count
irq_o  out  1  latched fault interrupt
reset_req_o  out  1  latched reset request
fault_code_o  out  2  0 none, 1 W timeout, 2 B timeout, 3 unsolicited B / overflow
fault_id_o  out  IdWidth  ID of faulting txn
fault_addr_o  out  AddrWidth  address of faulting txn (0 for unsolicited B)

Behaviour:
- Reset: all slots FREE; counters 0; irq_o, reset_req_o, fault_* = 0; full_o = 0; outstanding_o = 0.
- Slot states: FREE -> W_DATA on an AW handshake (aw_valid_o && aw_ready_i) into the lowest-index FREE slot. The slot captures id, addr and len; counter = 0. The slot index is pushed to an in-order W FIFO of depth MaxTxns.
- W handshakes apply to the slot at the W FIFO head. On a W handshake with w_last_i: pop the FIFO, move the slot W_DATA -> B_WAIT, counter = 0.
- B handshake: retire the B_WAIT slot with id == b_id_i that has the largest counter; on a tie, take the lowest index. The slot goes to FREE at the next edge.
- A B handshake with no matching B_WAIT slot is fault code 3, with fault_id_o = b_id_i.
- Counters increment by 1 each cycle in W_DATA/B_WAIT and saturate at all-ones.
- W budget limit = budget_w_i * (aw_len+1), computed at CntWidth+8 bits. A W_DATA slot whose counter exceeds the limit faults with code 1.
- A B_WAIT slot whose counter exceeds budget_b_i faults with code 2.
- Budget 0 disables the check for that phase.
- Faulted slot returns to FREE; its W FIFO entry is flushed on clear.
- Fault latch:
  - The first fault sets irq_o and reset_req_o and captures fault_* on the next edge.
  - Later faults are ignored until clear_i.
  - Multiple faults in the same cycle: lowest slot index wins; code 3 from B loses to a slot timeout.
- clear_i (1-cycle pulse): latch cleared and all slots/FIFO flushed at the next edge. clear_i has priority over simultaneous AW/B events.
- Full:
  - BlockWhenFull=1: aw_valid_o = aw_valid_i && !full_o and aw_ready_o = aw_ready_i && !full_o, combinational.
  - BlockWhenFull=0: pass-through, and an AW handshake while full raises fault code 3 with that ID/addr.
- A slot freed by B in cycle N is allocatable in cycle N+1, not N.
- AW and B handshakes in the same cycle are both processed.
- W may precede AW; such beats are ignored (not tracked). W_DATA counting starts at the AW handshake.
- enable_i=0: slots held FREE, no faults raised; the latch retains its value.
- Async reset mid-burst: everything returns to reset values immediately.

Test Plan:
- AW id=3 len=3, 4 W beats 1/cycle, B id=3 after 5 cycles, budgets 4/10 -> no fault, outstanding 1->0.
- budget_w=2, AW len=1, W withheld -> fault_code=1 on cycle 5 after AW, irq_o=reset_req_o=1, fault_addr=AW addr; clear_i -> all 0.
- Two AWs id=5 (addr A then B), W complete, one B id=5 -> the A slot retires first; budget_b=3 and second B absent -> code 2 with addr B.
- B id=7 with no outstanding txn -> code 3, fault_id=7, fault_addr=0.
- MaxTxns=8, 8 AWs unanswered, BlockWhenFull=1 -> full_o=1, 9th aw_ready_o=0; BlockWhenFull=0 -> 9th AW raises code 3.
- Assert rst_ni low with 3 outstanding and a latched fault -> all outputs 0 asynchronously, slots FREE after release.

Source files
------------

// File: rtl/axi_wr_txn_monitor.sv
// axi_wr_txn_monitor: passive AXI4 write-path watchdog with per-phase cycle budgets and a latched fault record
// Ports: clk_i/rst_ni (async, active-low); enable_i/clear_i control; aw_*/w_*/b_* channel taps;
//   aw_valid_o/aw_ready_o gated AW handshake; budget_w_i/budget_b_i phase budgets (0 = off);
//   full_o/outstanding_o tracker status; irq_o/reset_req_o/fault_code_o/fault_id_o/fault_addr_o fault record.
module axi_wr_txn_monitor #(
  parameter int IdWidth = 4,
  parameter int AddrWidth = 32,
  parameter int MaxTxns = 8,
  parameter int CntWidth = 16,
  parameter bit BlockWhenFull = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic                         aw_valid_i,
  input  logic                         aw_ready_i,
  input  logic [IdWidth-1:0]           aw_id_i,
  input  logic [AddrWidth-1:0]         aw_addr_i,
  input  logic [7:0]                   aw_len_i,
  output logic                         aw_valid_o,
  output logic                         aw_ready_o,
  input  logic                         w_valid_i,
  input  logic                         w_ready_i,
  input  logic                         w_last_i,
  input  logic                         b_valid_i,
  input  logic                         b_ready_i,
  input  logic [IdWidth-1:0]           b_id_i,
  input  logic [CntWidth-1:0]          budget_w_i,
  input  logic [CntWidth-1:0]          budget_b_i,
  input  logic                         clear_i,
  output logic                         full_o,
  output logic [$clog2(MaxTxns+1)-1:0] outstanding_o,
  output logic                         irq_o,
  output logic                         reset_req_o,
  output logic [1:0]                   fault_code_o,
  output logic [IdWidth-1:0]           fault_id_o,
  output logic [AddrWidth-1:0]         fault_addr_o
);
  localparam int IW = $clog2(MaxTxns);
  localparam int OW = $clog2(MaxTxns + 1);
  localparam int LW = CntWidth + 8;
  typedef enum logic [1:0] {FREE, W_DATA, B_WAIT} slot_e;
  slot_e                st_q [MaxTxns], st_d [MaxTxns];
  logic [IdWidth-1:0]   id_q [MaxTxns], id_d [MaxTxns];
  logic [AddrWidth-1:0] addr_q [MaxTxns], addr_d [MaxTxns];
  logic [7:0]           len_q [MaxTxns], len_d [MaxTxns];
  logic [CntWidth-1:0]  cnt_q [MaxTxns], cnt_d [MaxTxns];
  logic [IW-1:0]        fifo_q [MaxTxns], fifo_d [MaxTxns];
  logic [IW-1:0]        rd_q, rd_d, wr_q, wr_d;
  logic [OW-1:0]        fcnt_q, fcnt_d;
  logic                 irq_q, irq_d;
  logic [1:0]           code_q, code_d;
  logic [IdWidth-1:0]   fid_q, fid_d;
  logic [AddrWidth-1:0] faddr_q, faddr_d;
  logic                 aw_hs, w_hs, b_hs, alloc_ok, b_hit, head_live, w_done, push, pop, f_any;
  logic [IW-1:0]        alloc_idx, b_idx, head;
  logic [MaxTxns-1:0]   to;
  logic [1:0]           f_code;
  logic [IdWidth-1:0]   f_id;
  logic [AddrWidth-1:0] f_addr;
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
    return p == IW'(MaxTxns - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    outstanding_o = '0;
    for (int i = 0; i < MaxTxns; i++) outstanding_o = outstanding_o + OW'(st_q[i] != FREE);
    full_o = outstanding_o == OW'(MaxTxns);
  end
  assign aw_valid_o = aw_valid_i && !(BlockWhenFull && full_o);
  assign aw_ready_o = aw_ready_i && !(BlockWhenFull && full_o);
  // a slot times out once its counter has reached the limit, i.e. it would exceed it at this edge
  always_comb begin
    to = '0;
    for (int i = 0; i < MaxTxns; i++)
      to[i] = (st_q[i] == W_DATA && budget_w_i != '0 &&
               LW'(cnt_q[i]) >= LW'(budget_w_i) * (LW'(len_q[i]) + LW'(1))) ||
              (st_q[i] == B_WAIT && budget_b_i != '0 && cnt_q[i] >= budget_b_i);
  end
  always_comb begin
    aw_hs = aw_valid_o && aw_ready_i;
    w_hs = w_valid_i && w_ready_i;
    b_hs = b_valid_i && b_ready_i;
    alloc_ok = 1'b0;
    alloc_idx = '0;
    for (int i = MaxTxns - 1; i >= 0; i--)
      if (st_q[i] == FREE) begin
        alloc_ok = 1'b1;
        alloc_idx = IW'(i);
      end
    b_hit = 1'b0;
    b_idx = '0;
    for (int i = 0; i < MaxTxns; i++)
      if (st_q[i] == B_WAIT && id_q[i] == b_id_i && (!b_hit || cnt_q[i] > cnt_q[b_idx])) begin
        b_hit = 1'b1;
        b_idx = IW'(i);
      end
    head = fifo_q[rd_q];
    head_live = fcnt_q != '0 && st_q[head] == W_DATA;
    w_done = w_hs && w_last_i && head_live;
    push = aw_hs && alloc_ok;
    // entries of slots that timed out in W_DATA are dropped when they reach the head
    pop = fcnt_q != '0 && (!head_live || w_done);
    st_d = st_q;
    id_d = id_q;
    addr_d = addr_q;
    len_d = len_q;
    fifo_d = fifo_q;
    for (int i = 0; i < MaxTxns; i++) begin
      cnt_d[i] = st_q[i] == FREE ? '0 : cnt_q[i] + CntWidth'(~&cnt_q[i]);
      if (b_hs && b_hit && b_idx == IW'(i)) st_d[i] = FREE;
      if (w_done && head == IW'(i)) begin
        st_d[i] = B_WAIT;
        cnt_d[i] = '0;
      end
      if (to[i]) st_d[i] = FREE;
    end
    wr_d = wr_q;
    if (push) begin
      st_d[alloc_idx] = W_DATA;
      id_d[alloc_idx] = aw_id_i;
      addr_d[alloc_idx] = aw_addr_i;
      len_d[alloc_idx] = aw_len_i;
      cnt_d[alloc_idx] = '0;
      fifo_d[wr_q] = alloc_idx;
      wr_d = nxt(wr_q);
    end
    rd_d = pop ? nxt(rd_q) : rd_q;
    fcnt_d = fcnt_q + OW'(push) - OW'(pop);
    f_any = to != '0 || (b_hs && !b_hit) || (!BlockWhenFull && aw_hs && full_o);
    f_code = 2'd3;
    f_id = b_hs && !b_hit ? b_id_i : aw_id_i;
    f_addr = b_hs && !b_hit ? '0 : aw_addr_i;
    for (int i = MaxTxns - 1; i >= 0; i--)
      if (to[i]) begin
        f_code = st_q[i] == W_DATA ? 2'd1 : 2'd2;
        f_id = id_q[i];
        f_addr = addr_q[i];
      end
    irq_d = irq_q;
    code_d = code_q;
    fid_d = fid_q;
    faddr_d = faddr_q;
    if (!irq_q && f_any && enable_i) begin
      irq_d = 1'b1;
      code_d = f_code;
      fid_d = f_id;
      faddr_d = f_addr;
    end
    if (clear_i || !enable_i) begin
      st_d = '{default: FREE};
      cnt_d = '{default: '0};
      rd_d = '0;
      wr_d = '0;
      fcnt_d = '0;
    end
    if (clear_i) begin
      irq_d = 1'b0;
      code_d = '0;
      fid_d = '0;
      faddr_d = '0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      st_q <= '{default: FREE};
      id_q <= '{default: '0};
      addr_q <= '{default: '0};
      len_q <= '{default: '0};
      cnt_q <= '{default: '0};
      fifo_q <= '{default: '0};
      rd_q <= '0;
      wr_q <= '0;
      fcnt_q <= '0;
      irq_q <= 1'b0;
      code_q <= '0;
      fid_q <= '0;
      faddr_q <= '0;
    end else begin
      st_q <= st_d;
      id_q <= id_d;
      addr_q <= addr_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      fifo_q <= fifo_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      fcnt_q <= fcnt_d;
      irq_q <= irq_d;
      code_q <= code_d;
      fid_q <= fid_d;
      faddr_q <= faddr_d;
    end
  assign irq_o = irq_q;
  assign reset_req_o = irq_q;
  assign fault_code_o = code_q;
  assign fault_id_o = fid_q;
  assign fault_addr_o = faddr_q;
endmodule

// File: tb/tb_axi_wr_txn_monitor.sv
// tb_axi_wr_txn_monitor: directed self-checking bench for the blocking and pass-through monitor variants
module tb_axi_wr_txn_monitor;
  logic clk_i = 1'b0, rst_ni = 1'b0, enable_i = 1'b1, clear_i = 1'b0;
  logic aw_valid_i = 1'b0, aw_ready_i = 1'b0;
  logic [3:0] aw_id_i = '0, b_id_i = '0;
  logic [31:0] aw_addr_i = '0;
  logic [7:0] aw_len_i = '0;
  logic w_valid_i = 1'b0, w_ready_i = 1'b0, w_last_i = 1'b0, b_valid_i = 1'b0, b_ready_i = 1'b0;
  logic [15:0] budget_w_i = '0, budget_b_i = '0;
  logic aw_valid_o, aw_ready_o, full_o, irq_o, reset_req_o;
  logic aw_valid_n, aw_ready_n, full_n, irq_n, reset_req_n;
  logic [3:0] outstanding_o, outstanding_n, fault_id_o, fault_id_n;
  logic [1:0] fault_code_o, fault_code_n;
  logic [31:0] fault_addr_o, fault_addr_n;
  logic [63:0] rec, rec_n;
  logic [63:0] sb[$];
  int compares = 0, fails = 0;
  always #5 clk_i = ~clk_i;
  axi_wr_txn_monitor #(.BlockWhenFull(1'b1)) dut (
    .clk_i, .rst_ni, .enable_i, .aw_valid_i, .aw_ready_i, .aw_id_i, .aw_addr_i, .aw_len_i,
    .aw_valid_o(aw_valid_o), .aw_ready_o(aw_ready_o), .w_valid_i, .w_ready_i, .w_last_i,
    .b_valid_i, .b_ready_i, .b_id_i, .budget_w_i, .budget_b_i, .clear_i,
    .full_o(full_o), .outstanding_o(outstanding_o), .irq_o(irq_o), .reset_req_o(reset_req_o),
    .fault_code_o(fault_code_o), .fault_id_o(fault_id_o), .fault_addr_o(fault_addr_o));
  axi_wr_txn_monitor #(.BlockWhenFull(1'b0)) dut_n (
    .clk_i, .rst_ni, .enable_i, .aw_valid_i, .aw_ready_i, .aw_id_i, .aw_addr_i, .aw_len_i,
    .aw_valid_o(aw_valid_n), .aw_ready_o(aw_ready_n), .w_valid_i, .w_ready_i, .w_last_i,
    .b_valid_i, .b_ready_i, .b_id_i, .budget_w_i, .budget_b_i, .clear_i,
    .full_o(full_n), .outstanding_o(outstanding_n), .irq_o(irq_n), .reset_req_o(reset_req_n),
    .fault_code_o(fault_code_n), .fault_id_o(fault_id_n), .fault_addr_o(fault_addr_n));
  assign rec = {24'd0, irq_o, reset_req_o, fault_code_o, fault_id_o, fault_addr_o};
  assign rec_n = {24'd0, irq_n, reset_req_n, fault_code_n, fault_id_n, fault_addr_n};
  function automatic logic [63:0] mk(input logic [1:0] code, input logic [3:0] id, input logic [31:0] addr);
    return {24'd0, code != 2'd0, code != 2'd0, code, id, addr};
  endfunction
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic sb_chk(input string tag, input logic [63:0] obs);
    if (sb.size() == 0) begin
      compares++;
      fails++;
      $error("FAIL %s: observed %0h expected a queued record", tag, obs);
    end else chk(tag, obs, sb.pop_front());
  endtask
  task automatic aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l);
    aw_valid_i = 1'b1;
    aw_ready_i = 1'b1;
    aw_id_i = id;
    aw_addr_i = a;
    aw_len_i = l;
    tick(1);
    aw_valid_i = 1'b0;
    aw_ready_i = 1'b0;
  endtask
  task automatic b(input logic [3:0] id);
    b_valid_i = 1'b1;
    b_ready_i = 1'b1;
    b_id_i = id;
    tick(1);
    b_valid_i = 1'b0;
    b_ready_i = 1'b0;
  endtask
  task automatic clear();
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
  endtask
  initial begin
    tick(2);
    chk("reset_rec", rec, 64'd0);
    chk("reset_occ", {full_o, outstanding_o}, 5'd0);
    rst_ni = 1'b1;
    tick(1);
    // clean burst: len 3, four beats, B five cycles later
    budget_w_i = 16'd4;
    budget_b_i = 16'd10;
    aw(4'd3, 32'h0000_1000, 8'd3);
    chk("t1_out_after_aw", outstanding_o, 4'd1);
    w_valid_i = 1'b1;
    w_ready_i = 1'b1;
    tick(3);
    w_last_i = 1'b1;
    tick(1);
    w_valid_i = 1'b0;
    w_ready_i = 1'b0;
    w_last_i = 1'b0;
    tick(4);
    chk("t1_out_b_wait", outstanding_o, 4'd1);
    b(4'd3);
    chk("t1_out_retired", outstanding_o, 4'd0);
    chk("t1_no_fault", rec, 64'd0);
    // W withheld: limit 2*(1+1)=4, latched five edges after the AW edge
    budget_w_i = 16'd2;
    aw(4'd9, 32'hA000_0000, 8'd1);
    sb.push_back(mk(2'd1, 4'd9, 32'hA000_0000));
    tick(4);
    chk("t2_no_early_fault", rec, 64'd0);
    tick(1);
    sb_chk("t2_w_timeout", rec);
    chk("t2_slot_freed", outstanding_o, 4'd0);
    clear();
    chk("t2_cleared", rec, 64'd0);
    // same ID twice: oldest B_WAIT retires, the younger one times out in B
    budget_w_i = 16'd0;
    budget_b_i = 16'd3;
    aw_valid_i = 1'b1;
    aw_ready_i = 1'b1;
    aw_id_i = 4'd5;
    aw_addr_i = 32'h0000_2000;
    aw_len_i = 8'd0;
    tick(1);
    aw_addr_i = 32'h0000_3000;
    w_valid_i = 1'b1;
    w_ready_i = 1'b1;
    w_last_i = 1'b1;
    sb.push_back(mk(2'd2, 4'd5, 32'h0000_3000));
    tick(1);
    aw_valid_i = 1'b0;
    aw_ready_i = 1'b0;
    tick(1);
    w_valid_i = 1'b0;
    w_ready_i = 1'b0;
    w_last_i = 1'b0;
    b(4'd5);
    chk("t3_one_left", outstanding_o, 4'd1);
    tick(2);
    chk("t3_no_early_fault", irq_o, 1'b0);
    tick(1);
    sb_chk("t3_b_timeout", rec);
    clear();
    // unsolicited B
    sb.push_back(mk(2'd3, 4'd7, 32'd0));
    b(4'd7);
    sb_chk("t4_unsolicited_b", rec);
    clear();
    chk("t4_cleared", rec, 64'd0);
    // disable flushes slots and suppresses faults
    budget_b_i = 16'd0;
    aw(4'd1, 32'h0000_4000, 8'd0);
    chk("t5_out_enabled", outstanding_o, 4'd1);
    enable_i = 1'b0;
    tick(1);
    chk("t5_out_disabled", outstanding_o, 4'd0);
    b(4'd7);
    chk("t5_no_fault_disabled", rec, 64'd0);
    enable_i = 1'b1;
    tick(1);
    // fill all eight slots
    for (int i = 0; i < 8; i++) aw(4'(i), 32'h0000_5000 + 32'(i * 16), 8'd0);
    chk("t6_full", {full_o, outstanding_o}, {1'b1, 4'd8});
    chk("t6_full_n", full_n, 1'b1);
    aw_valid_i = 1'b1;
    aw_ready_i = 1'b1;
    aw_id_i = 4'd9;
    aw_addr_i = 32'h0000_9000;
    #1;
    chk("t6_gated", {aw_valid_o, aw_ready_o}, 2'b00);
    chk("t6_pass_n", {aw_valid_n, aw_ready_n}, 2'b11);
    sb.push_back(mk(2'd3, 4'd9, 32'h0000_9000));
    tick(1);
    aw_valid_i = 1'b0;
    aw_ready_i = 1'b0;
    chk("t6_block_no_fault", rec, 64'd0);
    sb_chk("t6_overflow_n", rec_n);
    w_valid_i = 1'b1;
    w_ready_i = 1'b1;
    w_last_i = 1'b1;
    tick(1);
    w_valid_i = 1'b0;
    w_ready_i = 1'b0;
    w_last_i = 1'b0;
    b(4'd0);
    chk("t6_slot_freed", {full_o, outstanding_o}, {1'b0, 4'd7});
    clear();
    // async reset with three outstanding and a latched fault
    aw(4'd1, 32'h0000_6000, 8'd0);
    aw(4'd2, 32'h0000_6010, 8'd0);
    aw(4'd3, 32'h0000_6020, 8'd0);
    sb.push_back(mk(2'd3, 4'd7, 32'd0));
    b(4'd7);
    chk("t7_out_before", outstanding_o, 4'd3);
    sb_chk("t7_fault_before", rec);
    #2 rst_ni = 1'b0;
    #1;
    chk("t7_async_rec", rec, 64'd0);
    chk("t7_async_occ", {full_o, outstanding_o}, 5'd0);
    tick(2);
    rst_ni = 1'b1;
    tick(1);
    chk("t7_after_release", {irq_o, outstanding_o}, 5'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule
